pipe_stage: RTL

//  Generic parametrised pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready

---
 rtl/pipe_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipe_stage.sv
// Pipeline-stage register with valid/ready handshake, flush and optional 2-entry skid buffer.
// Control payload reads CTRL_NOP whenever the stage is empty; data payload holds its last value.
module pipe_stage #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter int unsigned       SKID     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              out_valid_q;
    logic [1:0]        occ_q;
    logic              accept;
    logic              emit;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid_q & out_ready;

    // in_ready: a flop in skid mode, a pass-through of out_ready in single-register mode
    generate
        if (SKID != 0) begin : g_skid_ready
            logic in_ready_q;
            // Registered ready breaks the combinational out_ready -> in_ready path
            always_ff @(posedge clk or posedge rst) begin
                if (rst) in_ready_q <= 1'b1;
                else     in_ready_q <= (state_d != ST_TWO);
            end
            assign in_ready = in_ready_q;
        end else begin : g_comb_ready
            assign in_ready = (state_q == ST_EMPTY) | out_ready;
        end
    endgenerate

    // Next-state and payload-register update; flush overrides any accept
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = CTRL_NOP;
            skid_ctrl_d = CTRL_NOP;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept && (SKID != 0)) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (emit) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = CTRL_NOP;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = CTRL_NOP;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = CTRL_NOP;
                    skid_ctrl_d = CTRL_NOP;
                end
            endcase
        end
    end

    // State, payload and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= CTRL_NOP;
            main_data_q <= '0;
            skid_ctrl_q <= CTRL_NOP;
            skid_data_q <= '0;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            out_valid_q <= (state_d != ST_EMPTY);
            occ_q       <= (state_d == ST_TWO) ? 2'd2 : ((state_d == ST_ONE) ? 2'd1 : 2'd0);
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = occ_q;

endmodule
